// File: rtl/monit_pkt_builder.sv
// Purpose: snapshots the hit/trigger monitor counters on request and streams them as a 15-word housekeeping packet.
// Latency: first word valid the cycle after the request is accepted; rd_out pulses the cycle after W14 transfers.
// Backpressure: valid/ready link, the word is held while stalled; TIMEOUT_CYC stalled cycles abort the packet.
// Build option: define MONIT_PKT_CRC_EN to make W14 a CRC-16/CCITT-FALSE instead of the additive checksum.
module monit_pkt_builder #(
    parameter logic [15:0] HDR_WORD    = 16'hEB90,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pkt_req_in,
    input  logic [7:0]  hit_monit_sel_in,
    input  logic [7:0]  hit_err_cnt_in,
    input  logic [7:0]  busy_err_cnt_in,
    input  logic [31:0] hit_cnt_0_in,
    input  logic [31:0] hit_cnt_1_in,
    input  logic [15:0] busy_cnt_in,
    input  logic [15:0] hit_start_cnt_in,
    input  logic [15:0] logic_match_cnt_in,
    input  logic [15:0] eff_trg_cnt_in,
    input  logic [15:0] coincid_trg_cnt_in,
    input  logic [15:0] ext_trg_cnt_in,
    input  logic [7:0]  trg_delay_in,
    output logic [15:0] dout_out,
    output logic        dout_vld_out,
    input  logic        dout_rdy_in,
    output logic        busy_out,
    output logic        rd_out,
    output logic        pkt_abort_out,
    output logic [7:0]  req_drop_cnt_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef MONIT_PKT_CRC_EN
    localparam logic [15:0] CHK_INIT = 16'hFFFF;
`else
    localparam logic [15:0] CHK_INIT = 16'h0000;
`endif

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  sidx;
    logic [15:0] snap [13];
    logic [15:0] chk;
    logic [7:0]  seq;
    logic [15:0] stall_cnt;
    logic [15:0] word;
    logic        sending;
    logic        accept;
    logic        xfer;
    logic        last;
    logic        timeout;

    // Folds one checksummed word into the running check value.
    function automatic logic [15:0] chk_upd(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
`ifdef MONIT_PKT_CRC_EN
        r = c;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = (r << 1) ^ 16'h1021;
            end else begin
                r = r << 1;
            end
        end
`else
        r = c + d;
`endif
        return r;
    endfunction

    assign sending = (state == SEND);
    assign accept  = (state == IDLE) && pkt_req_in;
    assign xfer    = sending && dout_rdy_in;
    assign last    = (idx == 4'd14);
    // The stalled cycle in progress is the TIMEOUT_CYC-th one when the count already holds TIMEOUT_CYC-1.
    assign timeout = sending && !dout_rdy_in && (stall_cnt == STALL_LIMIT);
    assign sidx    = idx - 4'd1;

    assign dout_out     = word;
    assign dout_vld_out = sending;
    assign busy_out     = sending;
    assign rd_out       = (state == DONE);

    // State register; async reset lets vld/busy drop immediately mid-packet.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, finish on W14 transfer or abort on stall timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: begin
                if (xfer && last) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output word mux; zero whenever no word is being offered.
    always_comb begin
        word = 16'h0000;
        if (sending) begin
            if (idx == 4'd0) begin
                word = HDR_WORD;
            end else if (last) begin
                word = chk;
            end else begin
                word = snap[sidx];
            end
        end
    end

    // Snapshot, word index, checksum and stall counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 13; i++) begin
                snap[i] <= 16'h0000;
            end
            idx       <= 4'd0;
            chk       <= 16'h0000;
            stall_cnt <= 16'h0000;
        end else if (accept) begin
            snap[0]   <= {seq, hit_monit_sel_in};
            snap[1]   <= {hit_err_cnt_in, busy_err_cnt_in};
            snap[2]   <= hit_cnt_0_in[31:16];
            snap[3]   <= hit_cnt_0_in[15:0];
            snap[4]   <= hit_cnt_1_in[31:16];
            snap[5]   <= hit_cnt_1_in[15:0];
            snap[6]   <= busy_cnt_in;
            snap[7]   <= hit_start_cnt_in;
            snap[8]   <= logic_match_cnt_in;
            snap[9]   <= eff_trg_cnt_in;
            snap[10]  <= coincid_trg_cnt_in;
            snap[11]  <= ext_trg_cnt_in;
            snap[12]  <= {8'h00, trg_delay_in};
            idx       <= 4'd0;
            chk       <= CHK_INIT;
            stall_cnt <= 16'h0000;
        end else if (sending) begin
            if (xfer) begin
                idx       <= idx + 4'd1;
                stall_cnt <= 16'h0000;
                if ((idx != 4'd0) && !last) begin
                    chk <= chk_upd(chk, word);
                end
            end else if (timeout) begin
                stall_cnt <= 16'h0000;
            end else begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end else begin
            stall_cnt <= 16'h0000;
        end
    end

    // Sequence number advances only for packets that complete.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            seq <= 8'h00;
        end else if (state == DONE) begin
            seq <= seq + 8'd1;
        end
    end

    // Abort pulse registered from the timeout condition so it lines up with vld falling.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pkt_abort_out <= 1'b0;
        end else begin
            pkt_abort_out <= timeout;
        end
    end

    // Saturating count of requests seen while a packet is in flight or finishing.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            req_drop_cnt_out <= 8'h00;
        end else if (pkt_req_in && (state != IDLE) && (req_drop_cnt_out != 8'hFF)) begin
            req_drop_cnt_out <= req_drop_cnt_out + 8'd1;
        end
    end

endmodule

// File: tb/tb_monit_pkt_builder.sv
// Testbench for monit_pkt_builder: randomized packets against a packet-level reference model.
// A driver issues requests and pushes the expected 15 words; a monitor pops and compares each transfer.
// Covers fixed vectors, ready toggling, stall timeout, dropped requests and async reset mid-packet.
module tb_monit_pkt_builder;

    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_req = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  sel, herr, berr, dly;
    logic [31:0] c0, c1;
    logic [15:0] busyc, hs, lm, eff, coin, ext;
    logic [15:0] dout;
    logic        vld, busy, rd, abrt;
    logic [7:0]  dropc;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    int seq_m = 0;
    int drop_m = 0;

    always #10 clk = ~clk;

    monit_pkt_builder dut (
        .clk_in(clk), .rst_in(rst), .pkt_req_in(pkt_req),
        .hit_monit_sel_in(sel), .hit_err_cnt_in(herr), .busy_err_cnt_in(berr),
        .hit_cnt_0_in(c0), .hit_cnt_1_in(c1), .busy_cnt_in(busyc),
        .hit_start_cnt_in(hs), .logic_match_cnt_in(lm), .eff_trg_cnt_in(eff),
        .coincid_trg_cnt_in(coin), .ext_trg_cnt_in(ext), .trg_delay_in(dly),
        .dout_out(dout), .dout_vld_out(vld), .dout_rdy_in(rdy),
        .busy_out(busy), .rd_out(rd), .pkt_abort_out(abrt),
        .req_drop_cnt_out(dropc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_t1();
        sel = 8'h05; herr = 8'h01; berr = 8'h00; c0 = 32'h00010002; c1 = 32'h3;
        busyc = 16'd4; hs = 16'd5; lm = 16'd6; eff = 16'd7; coin = 16'd8; ext = 16'd9; dly = 8'h0A;
    endtask

    task automatic rand_fields();
        sel = 8'($urandom); herr = 8'($urandom); berr = 8'($urandom); c0 = $urandom; c1 = $urandom;
        busyc = 16'($urandom); hs = 16'($urandom); lm = 16'($urandom); eff = 16'($urandom);
        coin = 16'($urandom); ext = 16'($urandom); dly = 8'($urandom);
    endtask

    // Reference model: the packet as a list of words built from the current fields and model seq.
    task automatic push_expected();
        logic [15:0] w[15];
        int s;
        logic [15:0] crc;
        w[0] = 16'hEB90;
        w[1] = {8'(seq_m), sel};
        w[2] = {herr, berr};
        w[3] = c0[31:16]; w[4] = c0[15:0];
        w[5] = c1[31:16]; w[6] = c1[15:0];
        w[7] = busyc; w[8] = hs; w[9] = lm; w[10] = eff; w[11] = coin; w[12] = ext;
        w[13] = {8'h00, dly};
        s = 0;
        for (int i = 1; i <= 13; i++) s += int'(w[i]);
        w[14] = 16'(s % 65536);
`ifdef MONIT_PKT_CRC_EN
        crc = 16'hFFFF;
        for (int i = 1; i <= 13; i++) begin
            for (int b = 15; b >= 0; b--) begin
                crc = (crc[15] ^ w[i][b]) ? ((crc << 1) ^ 16'h1021) : (crc << 1);
            end
        end
        w[14] = crc;
`else
        crc = 16'h0000;
        if (crc != 16'h0000) w[14] = crc;
`endif
        for (int i = 0; i < 15; i++) exp_q.push_back(w[i]);
    endtask

    // Monitor: compares every transferred word and checks hold stability while stalled.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_dat = 16'h0;
    always @(negedge clk) begin
        if (rst || !vld) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) check("hold", dout, prev_dat);
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL word: got %0h but no word expected at %0t", dout, $time);
                end else begin
                    check("word", dout, exp_q.pop_front());
                end
                prev_stall <= 1'b0;
            end else begin
                prev_stall <= 1'b1;
                prev_dat   <= dout;
            end
        end
    end

    // mode: 0 rdy=1, 1 toggle, 2 random, 3 stall after stall_after words, 4 reset after reset_after words
    task automatic run_pkt(input int mode, input int stall_after, input int drop_pulses,
                           input int hold_drops, input int reset_after);
        int xf = 0;
        int stall = 0;
        int cyc = 0;
        bit done = 0;
        push_expected();
        @(posedge clk); #1;
        pkt_req = 1'b1;
        @(posedge clk); #1;
        pkt_req = 1'b0;
        rand_fields();
        check("vld_latency", vld, 1);
        check("busy_on_accept", busy, 1);
        while (!done && cyc < 5000) begin
            cyc++;
            case (mode)
                1:       rdy = (cyc % 2) == 1;
                2:       rdy = ($urandom % 2) == 1;
                3:       rdy = (xf < stall_after);
                default: rdy = 1'b1;
            endcase
            pkt_req = 1'b0;
            if (drop_pulses > 0 && (cyc % 2) == 0 && (cyc / 2) <= drop_pulses) pkt_req = 1'b1;
            if (mode == 3 && stall >= 5 && stall < 5 + hold_drops) pkt_req = 1'b1;
            if (pkt_req && drop_m < 255) drop_m++;
            if (vld && rdy) xf++;
            else if (vld) stall++;
            @(posedge clk);
            if (mode == 4 && xf == reset_after) begin
                #3 rst = 1'b1;
                #1;
                check("rst_vld", vld, 0);
                check("rst_busy", busy, 0);
                check("rst_dout", dout, 0);
                @(posedge clk); #1;
                check("rst_rd", rd, 0);
                rst = 1'b0;
                exp_q.delete();
                seq_m = 0;
                drop_m = 0;
                check("rst_drop", dropc, 0);
                done = 1;
            end else begin
                #1;
                if (rd) begin
                    check("words_before_rd", xf, 15);
                    check("vld_after_last", vld, 0);
                    seq_m = (seq_m + 1) % 256;
                    @(posedge clk); #1;
                    check("rd_one_cycle", rd, 0);
                    check("busy_end", busy, 0);
                    check("queue_drained", exp_q.size(), 0);
                    done = 1;
                end else if (abrt) begin
                    check("abort_expected", mode, 3);
                    check("stall_len", stall, TO);
                    check("abort_vld", vld, 0);
                    @(posedge clk); #1;
                    check("abort_one_cycle", abrt, 0);
                    check("abort_no_rd", rd, 0);
                    exp_q.delete();
                    done = 1;
                end
            end
        end
        pkt_req = 1'b0;
        if (!done) check("packet_end_seen", 0, 1);
        check("drop_cnt", dropc, drop_m);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        set_t1();
        #25;
        check("reset_dout", dout, 0);
        check("reset_vld", vld, 0);
        check("reset_busy", busy, 0);
        check("reset_rd", rd, 0);
        check("reset_abort", abrt, 0);
        check("reset_drop", dropc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        set_t1(); run_pkt(0, 0, 0, 0, 0);
        set_t1(); run_pkt(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            rand_fields();
            run_pkt(2, 0, 0, 0, 0);
        end
        rand_fields(); run_pkt(0, 0, 3, 0, 0);
        set_t1();      run_pkt(3, 4, 0, 271, 0);
        set_t1();      run_pkt(0, 0, 0, 0, 0);
        rand_fields(); run_pkt(4, 0, 0, 0, 7);
        set_t1();      run_pkt(0, 0, 0, 0, 0);
        rand_fields(); run_pkt(2, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
